// File: rtl/xw_pkg.sv
// Shared types and default widths for the X/W memory-style bus.
package xw_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} xw_init_state_t;

  typedef enum logic {PORT_X = 1'b0, PORT_W = 1'b1} xw_port_t;

  localparam int XW_AW = 16;
  localparam int XW_DW = 16;

endpackage

// File: rtl/xw_initiator.sv
// X/W bus initiator: takes one command at a time, issues a single-cycle strobe
// on X or W, captures X read data after RD_LAT cycles and returns one response.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// ISSUE   | strobe cycle on X or W (addr/data valid)
// WAIT_RD | counting down until xa_data_rd is valid
// RESP    | rsp_valid high until the consumer takes it
module xw_initiator
  import xw_pkg::*;
#(
  parameter int AW     = XW_AW,
  parameter int DW     = XW_DW,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic          cmd_port,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          xa_wr_s,
  output logic          xa_rd_s,
  output logic [AW-1:0] xa_addr,
  output logic [DW-1:0] xa_data_wr,
  input  logic [DW-1:0] xa_data_rd,
  output logic          wa_wr_s,
  output logic [AW-1:0] wa_addr,
  output logic [DW-1:0] wa_data_wr
);

  // Counter preload so that the last WAIT_RD cycle is the RD_LAT-th after the strobe.
  localparam logic [2:0] RD_CNT_INIT = 3'(RD_LAT - 1);

  xw_init_state_t state_q, state_d;
  logic           we_q;
  xw_port_t       port_q;
  logic [2:0]     cnt_q;

  logic accept;
  logic cmd_on_x;
  logic cmd_illegal;
  logic rd_sample;
  logic rsp_done;

  assign cmd_ready   = (state_q == IDLE);
  assign accept      = cmd_valid && cmd_ready;
  assign cmd_on_x    = (xw_port_t'(cmd_port) == PORT_X);
  // A read on W has no strobe to issue; it is answered directly with an error.
  assign cmd_illegal = !cmd_we && !cmd_on_x;
  assign rd_sample   = (state_q == WAIT_RD) && (cnt_q == 3'd0);
  assign rsp_done    = rsp_valid && rsp_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = cmd_illegal ? RESP : ISSUE;
      ISSUE:   state_d = (!we_q && port_q == PORT_X) ? WAIT_RD : RESP;
      WAIT_RD: if (cnt_q == 3'd0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command register: direction and port steer the ISSUE -> WAIT_RD/RESP choice.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      we_q   <= 1'b0;
      port_q <= PORT_X;
    end else if (accept) begin
      we_q   <= cmd_we;
      port_q <= xw_port_t'(cmd_port);
    end
  end

  // Read latency down-counter, loaded on the strobe cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                                   cnt_q <= 3'd0;
    else if (state_q == ISSUE)                    cnt_q <= RD_CNT_INIT;
    else if (state_q == WAIT_RD && cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
  end

  // Bus outputs: strobes pulse for the ISSUE cycle; addr/data hold their last value.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      xa_wr_s    <= 1'b0;
      xa_rd_s    <= 1'b0;
      wa_wr_s    <= 1'b0;
      xa_addr    <= '0;
      xa_data_wr <= '0;
      wa_addr    <= '0;
      wa_data_wr <= '0;
    end else begin
      xa_wr_s <= accept && cmd_we && cmd_on_x;
      xa_rd_s <= accept && !cmd_we && cmd_on_x;
      wa_wr_s <= accept && cmd_we && !cmd_on_x;
      if (accept && cmd_on_x) begin
        xa_addr <= cmd_addr;
        if (cmd_we) xa_data_wr <= cmd_wdata;
      end
      if (accept && cmd_we && !cmd_on_x) begin
        wa_addr    <= cmd_addr;
        wa_data_wr <= cmd_wdata;
      end
    end
  end

  // Response register: held through backpressure, cleared on handshake.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= (state_d == RESP);
      if (accept)        rsp_err <= cmd_illegal;
      else if (rsp_done) rsp_err <= 1'b0;
      if (rd_sample)     rsp_rdata <= xa_data_rd;
      else if (rsp_done) rsp_rdata <= '0;
    end
  end

endmodule
